// File: rtl/hero_input_ctrl_pkg.sv
// Shared codes for the HEROE hero input path: screens, keypad keys, hero actions
// and the action FSM state encoding.
package heroe_pkg;

  typedef enum logic [2:0] {
    SCR_OFF  = 3'd0,
    SCR_WLCM = 3'd1,
    SCR_CH   = 3'd2,
    SCR_GAME = 3'd3,
    SCR_WL   = 3'd4,
    SCR_PA   = 3'd5
  } screen_t;

  typedef enum logic [4:0] {
    KEY_CROUCH = 5'd0,
    KEY_LEFT   = 5'd4,
    KEY_OK     = 5'd5,
    KEY_RIGHT  = 5'd6,
    KEY_FLY    = 5'd8,
    KEY_JUMP   = 5'd9
  } key_t;

  typedef enum logic [1:0] {
    ACT_IDLE   = 2'd0,
    ACT_JUMP   = 2'd1,
    ACT_FLY    = 2'd2,
    ACT_CROUCH = 2'd3
  } act_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_COOLDOWN
  } act_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Non-action keys map to ACT_IDLE, which the FSM treats as "no action".
  function automatic logic [1:0] action_of(input logic [4:0] k);
    case (k)
      KEY_JUMP:   return ACT_JUMP;
      KEY_FLY:    return ACT_FLY;
      KEY_CROUCH: return ACT_CROUCH;
      default:    return ACT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/hero_input_ctrl_key_debounce.sv
// Debounces the raw keypad "key down" level into one-shot press/release events,
// latching the key code on the qualifying press edge.
module key_debounce #(
  parameter int DEBOUNCE = 16,
  parameter int CW       = $clog2(DEBOUNCE + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw,
  input  logic [4:0] key,
  output logic       press_evt,
  output logic       rel_evt,
  output logic [4:0] key_q
);

  logic          level;
  logic [CW-1:0] cnt;

  // Any cycle where raw agrees with the debounced level restarts the qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level     <= 1'b0;
      cnt       <= '0;
      press_evt <= 1'b0;
      rel_evt   <= 1'b0;
      key_q     <= '0;
    end else begin
      press_evt <= 1'b0;
      rel_evt   <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        level <= raw;
        cnt   <= '0;
        if (raw) begin
          press_evt <= 1'b1;
          key_q     <= key;
        end else begin
          rel_evt <= 1'b1;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/hero_input_ctrl.sv
// Keypad-to-hero control: hero selection on the CH screen and timed hero
// actions (with cooldown) on the GAME screen.
module hero_input_ctrl
  import heroe_pkg::*;
#(
  parameter int N_HEROES  = 5,
  parameter int HERO_W    = 3,
  parameter int WRAP      = 0,
  parameter int DEBOUNCE  = 16,
  parameter int ACT_HOLD  = 25_000_000,
  parameter int COOLDOWN  = 5_000_000,
  parameter int HOLD_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              keypad_pressed,
  input  logic [4:0]        key,
  input  logic [2:0]        presente,
  output logic [HERO_W-1:0] tipo_h,
  output logic [1:0]        var_h,
  output logic              sel_confirm,
  output logic              act_busy
);

  localparam int CW = $clog2(max3(ACT_HOLD, COOLDOWN, DEBOUNCE) + 1);
  localparam logic [HERO_W-1:0] LAST = HERO_W'(N_HEROES - 1);

  logic          press_evt;
  logic          rel_evt;
  logic [4:0]    key_q;
  act_state_t    state;
  logic [CW-1:0] act_cnt;
  logic          act_done;
  logic          cool_done;
  logic [1:0]    new_act;

  key_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .CW       (CW)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (keypad_pressed),
    .key       (key),
    .press_evt (press_evt),
    .rel_evt   (rel_evt),
    .key_q     (key_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tipo_h      <= '0;
      sel_confirm <= 1'b0;
    end else begin
      sel_confirm <= 1'b0;
      if (press_evt && presente == SCR_CH) begin
        case (key_q)
          KEY_LEFT: begin
            if (tipo_h != '0)      tipo_h <= tipo_h - HERO_W'(1);
            else if (WRAP != 0)    tipo_h <= LAST;
          end
          KEY_RIGHT: begin
            if (tipo_h != LAST)    tipo_h <= tipo_h + HERO_W'(1);
            else if (WRAP != 0)    tipo_h <= '0;
          end
          KEY_OK:  sel_confirm <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    act_done  = (HOLD_MODE != 0) ? rel_evt : (act_cnt == CW'(ACT_HOLD - 1));
    cool_done = (act_cnt == CW'(COOLDOWN - 1));
    new_act   = action_of(key_q);
  end

  // Leaving GAME wins over everything, including a press arriving the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      act_cnt  <= '0;
      var_h    <= ACT_IDLE;
      act_busy <= 1'b0;
    end else if (presente != SCR_GAME) begin
      state    <= ST_IDLE;
      act_cnt  <= '0;
      var_h    <= ACT_IDLE;
      act_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press_evt && new_act != ACT_IDLE) begin
            state    <= ST_ACTIVE;
            act_cnt  <= '0;
            var_h    <= new_act;
            act_busy <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (act_done) begin
            var_h   <= ACT_IDLE;
            act_cnt <= '0;
            if (COOLDOWN == 0) begin
              state    <= ST_IDLE;
              act_busy <= 1'b0;
            end else begin
              state <= ST_COOLDOWN;
            end
          end else begin
            act_cnt <= act_cnt + CW'(1);
          end
        end
        ST_COOLDOWN: begin
          if (cool_done) begin
            state    <= ST_IDLE;
            act_cnt  <= '0;
            act_busy <= 1'b0;
          end else begin
            act_cnt <= act_cnt + CW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          act_cnt  <= '0;
          var_h    <= ACT_IDLE;
          act_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
